// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default constants for the data-memory arbiter.
//   state_e : sequencer states (IDLE, ACCESS, RESP)
//   gid_t   : requester / grant identifier (0 = CPU, 1 = debug loader)
//   DEF_*   : default address/data widths and implemented memory depth
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int PERF_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef logic gid_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-input picker.
//   valid0_i, valid1_i : request lines
//   last_grant_i       : requester granted most recently
//   grant_o            : winning requester id
//   grant_valid_o      : at least one request is present
// Parameter FIXED_PRIO: 0 = round-robin on ties, 1 = requester 0 always wins.
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic valid0_i,
    input  logic valid1_i,
    input  gid_t last_grant_i,
    output gid_t grant_o,
    output logic grant_valid_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_o       = 1'b0;
        grant_valid_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            // On a tie, round-robin hands the grant to whoever did not win last.
            grant_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_i;
        end else if (valid1_i) begin
            grant_o = 1'b1;
        end
    end

endmodule : rr_arb2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter and access sequencer for a single-port data memory.
// Requester 0 is the CPU load/store stage, requester 1 the debug/program
// loader. One transaction at a time: IDLE (accept) -> ACCESS (optional wait
// states, then one sample/write cycle) -> RESP (one-cycle response).
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata         request from requester N (held until ready)
//   reqN_ready                       combinational accept strobe
//   rspN_valid                       one-cycle response strobe
//   rsp_rdata, rsp_err               shared registered read data / range error
//   mem_addr, mem_we, mem_wdata      memory port drive
//   mem_rdata                        combinational memory read data
//   busy                             high in ACCESS or RESP
//   gnt_cnt0/1, conflict_cnt         performance counters (DMEM_ARB_PERF_EN only)
//
// Build option: define DMEM_ARB_PERF_EN to add the saturating counters.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = 0,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,

    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] gnt_cnt0,
    output logic [PERF_W-1:0] gnt_cnt1,
    output logic [PERF_W-1:0] conflict_cnt
`endif
);

    localparam logic [3:0]      WS_C    = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    gid_t              gid_q;
    gid_t              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    gid_t              gnt;
    logic              gnt_valid;
    logic              accept;
    logic              sample;
    logic              in_range;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .valid0_i      (req0_valid),
        .valid1_i      (req1_valid),
        .last_grant_i  (last_grant_q),
        .grant_o       (gnt),
        .grant_valid_o (gnt_valid)
    );

    assign accept   = (state_q == IDLE) && gnt_valid;
    assign sample   = (state_q == ACCESS) && (wcnt_q == WS_C);
    assign in_range = {1'b0, addr_q} < DEPTH_C;

    // Ready is gated by rst_n so neither requester sees an accept during reset.
    assign req0_ready = rst_n && accept && (gnt == 1'b0);
    assign req1_ready = rst_n && accept && (gnt == 1'b1);

    // Decoded purely from registered state, so mem_we has no combinational
    // path from the request inputs and drops as soon as reset clears state.
    assign mem_we     = sample && we_q && in_range;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign rsp0_valid = (state_q == RESP) && (gid_q == 1'b0);
    assign rsp1_valid = (state_q == RESP) && (gid_q == 1'b1);
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    wcnt_d  = '0;
                end
            end
            ACCESS: begin
                if (sample) begin
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gid_q        <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                gid_q        <= gnt;
                last_grant_q <= gnt;
                we_q         <= gnt ? req1_we    : req0_we;
                addr_q       <= gnt ? req1_addr  : req0_addr;
                wdata_q      <= gnt ? req1_wdata : req0_wdata;
            end
            if (sample) begin
                rdata_q <= (!we_q && in_range) ? mem_rdata : '0;
                err_q   <= !in_range;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [PERF_W-1:0] gnt_cnt0_q, gnt_cnt1_q, conflict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (accept && (gnt == 1'b0) && (gnt_cnt0_q != '1)) begin
                gnt_cnt0_q <= gnt_cnt0_q + 1'b1;
            end
            if (accept && (gnt == 1'b1) && (gnt_cnt1_q != '1)) begin
                gnt_cnt1_q <= gnt_cnt1_q + 1'b1;
            end
            if ((state_q == IDLE) && req0_valid && req1_valid && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Two instances share clk/rst_n:
//   dut_a : WAIT_STATES = 0, round-robin  (table-driven single transactions,
//           round-robin contention)
//   dut_b : WAIT_STATES = 3, fixed priority (priority, latency, mid-access reset)
// Each instance has its own 256-word memory model preloaded with ram[i] = i.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- dut_a signals ----------------
    logic          a_req0_valid = 0, a_req0_we = 0, a_req1_valid = 0, a_req1_we = 0;
    logic [AW-1:0] a_req0_addr = '0, a_req1_addr = '0;
    logic [DW-1:0] a_req0_wdata = '0, a_req1_wdata = '0;
    logic          a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid;
    logic [DW-1:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
    logic          a_rsp_err, a_mem_we, a_busy;
    logic [AW-1:0] a_mem_addr;

    // ---------------- dut_b signals ----------------
    logic          b_req0_valid = 0, b_req0_we = 0, b_req1_valid = 0, b_req1_we = 0;
    logic [AW-1:0] b_req0_addr = '0, b_req1_addr = '0;
    logic [DW-1:0] b_req0_wdata = '0, b_req1_wdata = '0;
    logic          b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
    logic [DW-1:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic          b_rsp_err, b_mem_we, b_busy;
    logic [AW-1:0] b_mem_addr;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] a_gnt_cnt0, a_gnt_cnt1, a_conflict_cnt;
    logic [15:0] b_gnt_cnt0, b_gnt_cnt1, b_conflict_cnt;
`endif

    dmem_arbiter #(.WAIT_STATES(0), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_req0_valid), .req0_we(a_req0_we), .req0_addr(a_req0_addr),
        .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready), .rsp0_valid(a_rsp0_valid),
        .req1_valid(a_req1_valid), .req1_we(a_req1_we), .req1_addr(a_req1_addr),
        .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready), .rsp1_valid(a_rsp1_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
`ifdef DMEM_ARB_PERF_EN
        , .gnt_cnt0(a_gnt_cnt0), .gnt_cnt1(a_gnt_cnt1), .conflict_cnt(a_conflict_cnt)
`endif
    );

    dmem_arbiter #(.WAIT_STATES(3), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr),
        .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid),
        .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr),
        .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef DMEM_ARB_PERF_EN
        , .gnt_cnt0(b_gnt_cnt0), .gnt_cnt1(b_gnt_cnt1), .conflict_cnt(b_conflict_cnt)
`endif
    );

    // ---------------- memory models ----------------
    logic [DW-1:0] ram_a [0:255];
    logic [DW-1:0] ram_b [0:255];
    int            a_we_cnt = 0;
    logic [AW-1:0] a_we_addr = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 32'(i);
            ram_b[i] = 32'(i);
        end
    end

    assign a_mem_rdata = (a_mem_addr < 15'd256) ? ram_a[a_mem_addr[7:0]] : '0;
    assign b_mem_rdata = (b_mem_addr < 15'd256) ? ram_b[b_mem_addr[7:0]] : '0;

    always @(posedge clk) begin
        if (a_mem_we && (a_mem_addr < 15'd256)) ram_a[a_mem_addr[7:0]] <= a_mem_wdata;
        if (b_mem_we && (b_mem_addr < 15'd256)) ram_b[b_mem_addr[7:0]] <= b_mem_wdata;
    end

    always @(negedge clk) begin
        if (a_mem_we) begin
            a_we_cnt  = a_we_cnt + 1;
            a_we_addr = a_mem_addr;
        end
    end

    // ---------------- table of single transactions for dut_a ----------------
    typedef struct {
        bit            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            exp_we_pulses;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic run_vec_a(input vec_t v, input int idx);
        int lat;
        bit got;
        int we_base;
        we_base = a_we_cnt;
        if (v.id == 1'b0) begin
            a_req0_valid = 1; a_req0_we = v.we; a_req0_addr = v.addr; a_req0_wdata = v.wdata;
        end else begin
            a_req1_valid = 1; a_req1_we = v.we; a_req1_addr = v.addr; a_req1_wdata = v.wdata;
        end
        #1;
        check($sformatf("v%0d ready", idx), 32'({a_req1_ready, a_req0_ready}), v.id ? 32'd2 : 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            a_req0_valid = 0;
            a_req1_valid = 0;
            #1;
            lat++;
            if (a_rsp0_valid || a_rsp1_valid) got = 1;
        end
        check($sformatf("v%0d latency", idx), 32'(lat), 32'd2);
        check($sformatf("v%0d rsp id", idx), 32'({a_rsp1_valid, a_rsp0_valid}), v.id ? 32'd2 : 32'd1);
        check($sformatf("v%0d rdata", idx), a_rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d err", idx), 32'(a_rsp_err), 32'(v.exp_err));
        @(posedge clk); #1;
        check($sformatf("v%0d idle", idx), 32'(a_busy), 32'd0);
        check($sformatf("v%0d we pulses", idx), 32'(a_we_cnt - we_base), 32'(v.exp_we_pulses));
        if (v.exp_we_pulses == 1)
            check($sformatf("v%0d we addr", idx), 32'(a_we_addr), 32'(v.addr));
    endtask

    task automatic do_reset();
        a_req0_valid = 0; a_req1_valid = 0; b_req0_valid = 0; b_req1_valid = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        int ngrant;
        int nrsp;
        int cyc;
        int lat;
        bit got;

        //                  id  we  addr    wdata          exp_rdata      err pulses
        vecs[0] = '{1'b0, 1'b0, 15'd5,   32'h0,        32'd5,         1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 15'd10,  32'hDEADBEEF, 32'h0,         1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 15'd10,  32'h0,        32'hDEADBEEF,  1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, 15'd255, 32'h12345678, 32'h0,         1'b0, 1};
        vecs[4] = '{1'b0, 1'b0, 15'd255, 32'h0,        32'h12345678,  1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 15'd200, 32'h0,        32'd200,       1'b0, 0};
        vecs[6] = '{1'b0, 1'b1, 15'd300, 32'hCAFEF00D, 32'h0,         1'b1, 0};
        vecs[7] = '{1'b1, 1'b0, 15'd300, 32'h0,        32'h0,         1'b1, 0};
        vecs[8] = '{1'b0, 1'b0, 15'd256, 32'h0,        32'h0,         1'b1, 0};
        vecs[9] = '{1'b0, 1'b0, 15'd7,   32'h0,        32'd7,         1'b0, 0};

        // ---------------- reset state, ready forced low during reset ----------------
        a_req0_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready0 forced low", 32'(a_req0_ready), 32'd0);
        check("reset busy", 32'(a_busy), 32'd0);
        check("reset mem_we", 32'(a_mem_we), 32'd0);
        check("reset mem_addr", 32'(a_mem_addr), 32'd0);
        check("reset mem_wdata", a_mem_wdata, 32'd0);
        check("reset rsp_rdata", a_rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(a_rsp_err), 32'd0);
        check("reset rsp valids", 32'({a_rsp1_valid, a_rsp0_valid}), 32'd0);
        a_req0_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;
        check("post-reset idle", 32'(a_busy), 32'd0);

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < NVEC; i++) begin
            run_vec_a(vecs[i], i);
        end
        check("ram_a[10] written", ram_a[10], 32'hDEADBEEF);

        // ---------------- round-robin contention ----------------
        do_reset();
`ifdef DMEM_ARB_PERF_EN
        check("perf reset gnt0", 32'(a_gnt_cnt0), 32'd0);
`endif
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 15'd1;
        a_req1_valid = 1; a_req1_we = 0; a_req1_addr = 15'd2;
        ngrant = 0;
        nrsp   = 0;
        cyc    = 0;
        while (ngrant < 4 && cyc < 40) begin
            @(negedge clk);
            check("rr one ready", 32'(a_req0_ready & a_req1_ready), 32'd0);
            if (a_req0_ready || a_req1_ready) begin
                check($sformatf("rr grant %0d", ngrant), 32'(a_req1_ready), 32'(ngrant % 2));
                ngrant++;
            end
            if (a_rsp0_valid) begin
                check("rr rsp0 data", a_rsp_rdata, 32'd1);
                nrsp++;
            end
            if (a_rsp1_valid) begin
                check("rr rsp1 data", a_rsp_rdata, 32'd2);
                nrsp++;
            end
            cyc++;
        end
        check("rr grants seen", 32'(ngrant), 32'd4);
        @(posedge clk); #1;
        a_req0_valid = 0;
        a_req1_valid = 0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            if (a_rsp0_valid || a_rsp1_valid) nrsp++;
            cyc++;
        end
        check("rr responses", 32'(nrsp), 32'd4);
`ifdef DMEM_ARB_PERF_EN
        check("perf gnt_cnt0", 32'(a_gnt_cnt0), 32'd2);
        check("perf gnt_cnt1", 32'(a_gnt_cnt1), 32'd2);
        check("perf conflict_cnt", 32'(a_conflict_cnt), 32'd4);
`endif

        // ---------------- dut_b: fixed priority ----------------
        @(posedge clk); #1;
        b_req0_valid = 1; b_req0_we = 0; b_req0_addr = 15'd3;
        b_req1_valid = 1; b_req1_we = 0; b_req1_addr = 15'd4;
        ngrant = 0;
        cyc    = 0;
        while (ngrant < 3 && cyc < 60) begin
            @(negedge clk);
            check("fp ready1 held low", 32'(b_req1_ready), 32'd0);
            if (b_req0_ready) ngrant++;
            cyc++;
        end
        check("fp req0 grants", 32'(ngrant), 32'd3);
        @(posedge clk); #1;
        b_req0_valid = 0;
        got = 0;
        cyc = 0;
        while (!got && cyc < 30) begin
            @(negedge clk);
            if (b_req1_ready) got = 1;
            cyc++;
        end
        check("fp req1 granted after drop", 32'(got), 32'd1);
        @(posedge clk); #1;
        b_req1_valid = 0;
        cyc = 0;
        while (b_busy && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("fp rsp1 data", b_rsp_rdata, 32'd4);

        // ---------------- dut_b: WAIT_STATES = 3 read latency ----------------
        b_req0_valid = 1; b_req0_we = 0; b_req0_addr = 15'd9;
        #1;
        check("ws3 ready0", 32'(b_req0_ready), 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            b_req0_valid = 0;
            #1;
            lat++;
            if (b_rsp0_valid) got = 1;
        end
        check("ws3 latency", 32'(lat), 32'd5);
        check("ws3 rdata", b_rsp_rdata, 32'd9);
        check("ws3 err", 32'(b_rsp_err), 32'd0);
        @(posedge clk); #1;

        // ---------------- dut_b: reset during the write sample cycle ----------------
        b_req1_valid = 1; b_req1_we = 1; b_req1_addr = 15'd20; b_req1_wdata = 32'hA5A5A5A5;
        #1;
        check("rst-mid ready1", 32'(b_req1_ready), 32'd1);
        @(posedge clk); #1;
        b_req1_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst-mid mem_we before reset", 32'(b_mem_we), 32'd1);
        rst_n = 0;
        #1;
        check("rst-mid mem_we drops", 32'(b_mem_we), 32'd0);
        check("rst-mid busy drops", 32'(b_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst-mid write suppressed", ram_b[20], 32'd20);
        rst_n = 1;
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b_rsp0_valid || b_rsp1_valid || b_busy) got = 1;
        end
        check("rst-mid no response", 32'(got), 32'd0);
        check("rst-mid mem_addr", 32'(b_mem_addr), 32'd0);
        check("rst-mid rsp_rdata", b_rsp_rdata, 32'd0);
        check("rst-mid mem_wdata", b_mem_wdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_arbiter
